// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers used by the control logic.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_PREP = 2'b01,
        MDU_RUN  = 2'b10,
        MDU_FIX  = 2'b11
    } mdu_state_e;

    function automatic logic is_div_op(input mdu_op_e o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for restoring result signs.
module mdu_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide
// on unsigned magnitudes, one bit per cycle, with signs fixed up at the end.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e         state;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               res_neg, rem_neg;

    logic               sgn_op, div_op;
    logic [WIDTH-1:0]   abs_a, abs_b, rem_fix, quo_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     mul_sum, rem_shift;
    logic [WIDTH-1:0]   rem_sub;

    assign sgn_op = is_signed_op(op_q);
    assign div_op = is_div_op(op_q);

    mdu_cond_neg #(.W(WIDTH)) u_neg_a (.in(a_q), .neg(sgn_op & a_q[WIDTH-1]), .out(abs_a));
    mdu_cond_neg #(.W(WIDTH)) u_neg_b (.in(b_q), .neg(sgn_op & b_q[WIDTH-1]), .out(abs_b));

    mdu_cond_neg #(.W(2*WIDTH)) u_neg_prod (.in(acc), .neg(res_neg), .out(prod_fix));
    mdu_cond_neg #(.W(WIDTH)) u_neg_rem (.in(acc[2*WIDTH-1:WIDTH]), .neg(rem_neg), .out(rem_fix));
    mdu_cond_neg #(.W(WIDTH)) u_neg_quo (.in(acc[WIDTH-1:0]), .neg(res_neg), .out(quo_fix));

    // acc holds {partial product} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_sub   = rem_shift[WIDTH-1:0] - opnd;

    always_comb begin
        // NOTE: acc_next gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        acc_next = acc;
        if (div_op) begin
            if (rem_shift >= {1'b0, opnd}) acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
            else                            acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= MDU_IDLE;
            op_q     <= MDU_MULT;
            a_q      <= '0;
            b_q      <= '0;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge register values.
            done <= 1'b0;
            case (state)
                MDU_IDLE: if (start) begin
                    op_q     <= mdu_op_e'(op);
                    a_q      <= src_a;
                    b_q      <= src_b;
                    busy     <= 1'b1;
                    div_zero <= 1'b0;
                    state    <= MDU_PREP;
                end
                MDU_PREP: begin
                    res_neg <= sgn_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rem_neg <= sgn_op & a_q[WIDTH-1];
                    cnt     <= '0;
                    if (div_op && (b_q == '0)) begin
                        div_zero <= 1'b1;
                        state    <= MDU_FIX;
                    end else begin
                        state <= MDU_RUN;
                        if (div_op) begin
                            opnd <= abs_b;
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            opnd <= abs_a;
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                        end
                    end
                end
                MDU_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= MDU_FIX;
                end
                MDU_FIX: begin
                    if (!div_zero) begin
                        if (div_op) {hi, lo} <= {rem_fix, quo_fix};
                        else        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// handshake/reset sequences and randomized ops against a 64-bit arithmetic model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference state: last committed hi/lo and the div-by-zero flag.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Plain-arithmetic model: 64-bit products, SV's truncating / and dividend-signed %.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        m_dz = 1'b0;
        case (o)
            2'b00: begin p = sa * sb; {m_hi, m_lo} = p; end
            2'b01: begin up = ua * ub; {m_hi, m_lo} = up; end
            2'b10: if (b == '0) m_dz = 1'b1;
                   else begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
            default: if (b == '0) m_dz = 1'b1;
                     else begin m_lo = W'(ua / ub); m_hi = W'(ua % ub); end
        endcase
    endfunction

    // Called mid-cycle (after a sampling point); start is driven immediately,
    // so back-to-back calls also exercise a start issued in the done cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int pulse_at);
        int lat, bcyc, exp_lat;
        bit seen, overlap;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        check({name, " accept"}, 64'({busy, done, div_zero}), 64'(3'b100));
        lat = 0; bcyc = busy ? 1 : 0; seen = 0; overlap = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (i == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done && busy) overlap = 1;
            if (done) seen = 1;
            else if (busy) bcyc++;
        end
        model(o, a, b);
        exp_lat = m_dz ? 2 : W + 2;
        check({name, " done_seen"}, 64'(seen), 64'(1));
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy_cycles"}, 64'(bcyc), 64'(exp_lat));
        check({name, " done_busy_overlap"}, 64'(overlap), 64'(0));
        check({name, " result"}, {hi, lo}, {m_hi, m_lo});
        check({name, " div_zero"}, 64'(div_zero), 64'(m_dz));
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[4] = '{2'b11, 32'd1234,     32'd0,        32'h00000002, 32'h0000000E, 1'b1};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8] = '{2'b01, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        vecs[9] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, done, div_zero, hi, lo}, 67'(0));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, -1);
            check($sformatf("vec%0d table", i), {hi, lo, 63'(div_zero)},
                  {vecs[i].hi, vecs[i].lo, 63'(vecs[i].dz)});
        end

        // Div-by-zero sticks until the next accepted start, which clears it.
        run_op("dz_set", 2'b10, 32'd55, 32'd0, -1);
        @(posedge clk); #1;
        check("dz_sticky", 64'({div_zero, done, busy}), 64'(3'b100));
        run_op("dz_clear", 2'b11, 32'd9, 32'd4, -1);

        // A start pulse while busy is ignored and never queued.
        run_op("mid_start", 2'b10, 32'h80000000, 32'hFFFFFFFF, 10);
        @(posedge clk); #1;
        check("mid_start no_requeue", 64'({busy, done}), 64'(0));

        // Asynchronous reset in the middle of a multiply clears the outputs at once.
        op = 2'b00; src_a = 32'h12345; src_b = 32'h6789; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("async_reset", {busy, done, div_zero, hi, lo}, 67'(0));
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset", 2'b01, 32'd6, 32'd7, -1);
        check("post_reset value", {hi, lo}, 64'h0000_0000_0000_002A);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin ra = W'($urandom_range(0, 1000)); rb = W'($urandom_range(1, 40)); end
                3: rb = W'($urandom_range(1, 3)) | (ra & 32'h80000000);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb, (i % 5 == 0) ? 7 : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
